kempston_mouse: RTL and testbench
=================================

Name: kempston_mouse

Overview:
- Kempston-compatible mouse interface for the zx128 core.
- Consumes the hps_io PS/2 mouse packet as the emu wrapper presents it: a one-cycle update pulse, active-low button triplet and 9-bit signed deltas.
- Accumulates the deltas into wrapping 8-bit X/Y position counters and serves them to the Z80 on the Kempston I/O ports.
- Sits between the wrapper's mouse decode and the zx128 CPU I/O read mux.

Parameters:
- DIV_SHIFT, 0, sensitivity divider. Each axis accumulator is 8+DIV_SHIFT bits wide; the CPU sees the top 8 bits. Legal range 0..3.
- INVERT_Y, 0, when 1 the Y delta is subtracted instead of added.

Ports:
- clock  in  1  system clock (clk_sys, 56.75 MHz).
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  1 = interface decodes and answers ports; 0 = never drives bus, accumulation continues.
- mouses  in  1  one-cycle update strobe, one per PS/2 packet.
- mouseb  in  3  buttons, active low: bit0 right, bit1 left, bit2 middle.
- mousex  in  9  signed X delta, two's complement, bit8 = sign.
- mousey  in  9  signed Y delta, two's complement, bit8 = sign, positive = up.
- a  in  16  Z80 address bus.
- iorq  in  1  Z80 IORQ, active low.
- rd  in  1  Z80 RD, active low.
- m1  in  1  Z80 M1, active low; used to exclude interrupt-acknowledge cycles.
- dout  out  8  read data.
- oe  out  1  1 = this block owns the CPU data bus this cycle.

Behaviour:
- Reset (asynchronous, reset=0):
  - X and Y accumulators = 0.
  - Button register = 3'b111.
  - dout = 8'hFF, oe = 0.
  - Strobes arriving while reset is low are discarded.
- Delta extension: mousex and mousey are sign-extended to 8+DIV_SHIFT bits. Example: 9'h1F6 becomes -10.
- Update, on the clock edge where mouses = 1:
  - accX <= accX + sext(mousex).
  - accY <= accY ± sext(mousey); sign set by INVERT_Y.
  - btn <= mouseb.
  - Single-cycle update; no saturation. Arithmetic wraps modulo 2^(8+DIV_SHIFT).
  - The fractional low bits carry across packets, so slow movement is not lost.
- Position outputs: posX = accX[top 8]; posY = accY[top 8].
- Port decode, valid when enable=1, iorq=0, rd=0, m1=1; only a[15:0] compared against these masks:
  - X: a[10:8]=3'b011, a[5]=0 (FBDF) -> posX.
  - Y: a[10:8]=3'b111, a[5]=0 (FFDF) -> posY.
  - Buttons: a[10:8]=3'b010, a[5]=0 (FADF) -> {5'b11111, btn}.
- Read timing:
  - dout and oe are registered: they reflect the decode one clock after the qualifying bus state and stay stable while it holds.
  - oe returns to 0 the clock after iorq or rd deasserts.
  - When oe=0, dout = 8'hFF.
- Read/update conflict: if an update strobe and a read coincide, the read returns the value before the update for that cycle. The next registered cycle of the same read shows the new value; no snapshotting across X/Y.
- enable=0 mid-read forces oe=0 on the next clock. Accumulators are unaffected.
- Reset asserted mid-read: oe=0 and dout=FF immediately (asynchronous).

Test Plan:
- Reset released, no strobe; read FBDF, FFDF, FADF -> 00, 00, FF; oe=1 one clock after decode.
- DIV_SHIFT=0: strobe with mousex=9'h005 then 9'h1FB -> posX 05, then 00.
- Wrap: posX=FE, strobe mousex=9'h003 -> 01. posY=02, mousey=9'h1FC -> FE; with INVERT_Y=1 the same packet -> 06.
- DIV_SHIFT=2: four strobes of mousex=+1 -> posX stays 00 for three strobes, then 01 on the fourth.
- Buttons: strobe with mouseb=3'b101 -> FADF reads FD. m1=0 with iorq=0 -> oe stays 0.
- Strobe during reset=0 ignored -> after release posX=00. Assert reset during an active read -> oe=0 and dout=FF with no clock edge.

Source files
------------

// File: rtl/kempston_mouse.sv
// Kempston mouse interface: accumulates PS/2 deltas into wrapping X/Y position
// counters and answers the Kempston I/O ports (FBDF, FFDF, FADF) on Z80 reads.
module kempston_mouse #(
  parameter int DIV_SHIFT = 0,
  parameter bit INVERT_Y  = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        mouses,
  input  logic [2:0]  mouseb,
  input  logic [8:0]  mousex,
  input  logic [8:0]  mousey,
  input  logic [15:0] a,
  input  logic        iorq,
  input  logic        rd,
  input  logic        m1,
  output logic [7:0]  dout,
  output logic        oe
);

  localparam int ACC_W = 8 + DIV_SHIFT;

  logic [8:0]  delta_raw [2];
  logic [15:0] pos_flat;
  logic [2:0]  btn_reg;
  logic        bus_rd;
  logic [7:0]  dout_next;
  logic        oe_next;
  logic        unused_bits;

  assign delta_raw[0] = mousex;
  assign delta_raw[1] = mousey;

  // One wrapping accumulator per axis; the CPU only ever sees its top 8 bits,
  // so the low DIV_SHIFT bits carry sub-count motion between packets.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_axis
      logic [ACC_W-1:0] delta;
      logic [ACC_W-1:0] acc_reg;
      logic [ACC_W-1:0] acc_next;

      assign delta = ACC_W'($signed(delta_raw[gi]));

      if (gi == 1 && INVERT_Y) begin : g_sub
        assign acc_next = acc_reg - delta;
      end else begin : g_add
        assign acc_next = acc_reg + delta;
      end

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          acc_reg <= '0;
        end else if (mouses) begin
          acc_reg <= acc_next;
        end
      end

      assign pos_flat[gi*8 +: 8] = acc_reg[ACC_W-1 -: 8];
    end
  endgenerate

  // Interrupt-acknowledge cycles (m1 low) also assert iorq; exclude them.
  assign bus_rd      = enable & ~iorq & ~rd & m1 & ~a[5];
  assign unused_bits = ^{a[15:11], a[7:6], a[4:0]};

  always_comb begin
    dout_next = 8'hFF;
    oe_next   = 1'b0;
    if (bus_rd) begin
      case (a[10:8])
        3'b011: begin
          dout_next = pos_flat[7:0];
          oe_next   = 1'b1;
        end
        3'b111: begin
          dout_next = pos_flat[15:8];
          oe_next   = 1'b1;
        end
        3'b010: begin
          dout_next = {5'b11111, btn_reg};
          oe_next   = 1'b1;
        end
        default: begin
          dout_next = 8'hFF;
          oe_next   = 1'b0;
        end
      endcase
    end
  end

  // Read data is captured from the pre-update accumulators on a strobe edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      btn_reg <= 3'b111;
      dout    <= 8'hFF;
      oe      <= 1'b0;
    end else begin
      dout <= dout_next;
      oe   <= oe_next;
      if (mouses) begin
        btn_reg <= mouseb;
      end
    end
  end

endmodule

// File: tb/tb_kempston_mouse.sv
// Bench for kempston_mouse: three configurations share one stimulus stream and
// are checked against an integer-arithmetic reference model plus literal reads.
module tb_kempston_mouse;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b1;
  logic        mouses = 1'b0;
  logic [2:0]  mouseb = 3'b111;
  logic [8:0]  mousex = '0;
  logic [8:0]  mousey = '0;
  logic [15:0] a = '0;
  logic        iorq = 1'b1;
  logic        rd = 1'b1;
  logic        m1 = 1'b1;

  logic [7:0]  d0, d1, d2;
  logic        o0, o1, o2;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  kempston_mouse #(.DIV_SHIFT(0), .INVERT_Y(1'b0)) dut0 (
    .clock(clock), .reset(reset), .enable(enable), .mouses(mouses), .mouseb(mouseb),
    .mousex(mousex), .mousey(mousey), .a(a), .iorq(iorq), .rd(rd), .m1(m1),
    .dout(d0), .oe(o0));
  kempston_mouse #(.DIV_SHIFT(0), .INVERT_Y(1'b1)) dut1 (
    .clock(clock), .reset(reset), .enable(enable), .mouses(mouses), .mouseb(mouseb),
    .mousex(mousex), .mousey(mousey), .a(a), .iorq(iorq), .rd(rd), .m1(m1),
    .dout(d1), .oe(o1));
  kempston_mouse #(.DIV_SHIFT(2), .INVERT_Y(1'b0)) dut2 (
    .clock(clock), .reset(reset), .enable(enable), .mouses(mouses), .mouseb(mouseb),
    .mousex(mousex), .mousey(mousey), .a(a), .iorq(iorq), .rd(rd), .m1(m1),
    .dout(d2), .oe(o2));

  // ---------------- reference model ----------------
  function automatic int ds_of(input int k);
    return (k == 2) ? 2 : 0;
  endfunction

  function automatic int sgn9(input logic [8:0] v);
    return v[8] ? (int'(v) - 512) : int'(v);
  endfunction

  function automatic int wrap(input int k, input int v);
    int m;
    m = 1 << (8 + ds_of(k));
    return ((v % m) + m) % m;
  endfunction

  function automatic int sel_of(input logic [15:0] ad, input logic en, input logic io,
                                input logic r, input logic m);
    if (!(en && !io && !r && m)) return 0;
    if ((ad & 16'h0720) == 16'h0300) return 1;
    if ((ad & 16'h0720) == 16'h0700) return 2;
    if ((ad & 16'h0720) == 16'h0200) return 3;
    return 0;
  endfunction

  int         acc_x [3];
  int         acc_y [3];
  logic [2:0] mbtn;
  logic [7:0] exp_d [3];
  logic       exp_o [3];

  always @(posedge clock or negedge reset) begin
    int s;
    int dy;
    if (!reset) begin
      for (int k = 0; k < 3; k++) begin
        acc_x[k] <= 0;
        acc_y[k] <= 0;
        exp_d[k] <= 8'hFF;
        exp_o[k] <= 1'b0;
      end
      mbtn <= 3'b111;
    end else begin
      s = sel_of(a, enable, iorq, rd, m1);
      for (int k = 0; k < 3; k++) begin
        exp_o[k] <= (s != 0);
        case (s)
          1:       exp_d[k] <= 8'((acc_x[k] >> ds_of(k)) & 255);
          2:       exp_d[k] <= 8'((acc_y[k] >> ds_of(k)) & 255);
          3:       exp_d[k] <= {5'b11111, mbtn};
          default: exp_d[k] <= 8'hFF;
        endcase
        if (mouses) begin
          dy = (k == 1) ? -sgn9(mousey) : sgn9(mousey);
          acc_x[k] <= wrap(k, acc_x[k] + sgn9(mousex));
          acc_y[k] <= wrap(k, acc_y[k] + dy);
        end
      end
      if (mouses) mbtn <= mouseb;
    end
  end

  // Every-cycle comparison of all three instances against the model.
  always @(negedge clock) begin
    if (reset) begin
      tests++;
      if (d0 !== exp_d[0] || o0 !== exp_o[0] || d1 !== exp_d[1] || o1 !== exp_o[1] ||
          d2 !== exp_d[2] || o2 !== exp_o[2]) begin
        fails++;
        $display("FAIL model t=%0t: got dout %h/%h/%h oe %b%b%b, want dout %h/%h/%h oe %b%b%b",
                 $time, d0, d1, d2, o0, o1, o2, exp_d[0], exp_d[1], exp_d[2],
                 exp_o[0], exp_o[1], exp_o[2]);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end else begin
      $display("[TB] %s: %h ok", nm, act);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b, want %b", nm, act, exp);
    end else begin
      $display("[TB] %s: %b ok", nm, act);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_bus();
    iorq = 1'b1;
    rd   = 1'b1;
    m1   = 1'b1;
  endtask

  task automatic strobe(input logic [8:0] x, input logic [8:0] y, input logic [2:0] b);
    idle_bus();
    mousex = x;
    mousey = y;
    mouseb = b;
    mouses = 1'b1;
    tick();
    mouses = 1'b0;
  endtask

  task automatic rd_port(input logic [15:0] addr);
    a    = addr;
    iorq = 1'b0;
    rd   = 1'b0;
    m1   = 1'b1;
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    tick();
    strobe(9'h005, 9'h005, 3'b000);        // discarded while in reset
    reset = 1'b1;
    tick();

    a = 16'hFBDF; iorq = 1'b0; rd = 1'b0; m1 = 1'b1;
    #1;
    chk1("oe before edge", o0, 1'b0);
    tick();
    chk1("oe after decode", o0, 1'b1);
    chk8("reset X", d0, 8'h00);
    rd_port(16'hFFDF);  chk8("reset Y", d0, 8'h00);
    rd_port(16'hFADF);  chk8("reset buttons", d0, 8'hFF);

    strobe(9'h005, 9'h002, 3'b111);
    rd_port(16'hFBDF);  chk8("X +5", d0, 8'h05);
    rd_port(16'hFFDF);  chk8("Y +2", d0, 8'h02);
    chk8("Y inv +2", d1, 8'hFE);
    strobe(9'h1FB, 9'h1FC, 3'b111);
    rd_port(16'hFBDF);  chk8("X -5", d0, 8'h00);
    rd_port(16'hFFDF);  chk8("Y wrap -4", d0, 8'hFE);
    chk8("Y inv -4", d1, 8'h02);
    strobe(9'h1FE, 9'h1FC, 3'b111);
    rd_port(16'hFBDF);  chk8("X to FE", d0, 8'hFE);
    rd_port(16'hFFDF);  chk8("Y inv 02->06", d1, 8'h06);
    strobe(9'h003, 9'h000, 3'b111);
    rd_port(16'hFBDF);  chk8("X wrap FE+3", d0, 8'h01);

    strobe(9'h000, 9'h000, 3'b101);
    rd_port(16'hFADF);  chk8("buttons 101", d0, 8'hFD);
    a = 16'hFADF; iorq = 1'b0; rd = 1'b0; m1 = 1'b0;
    tick();
    chk1("m1 low oe", o0, 1'b0);
    chk8("m1 low dout", d0, 8'hFF);

    // read/update collision: old value first, new value next cycle
    rd_port(16'hFBDF);  chk8("collide pre", d0, 8'h01);
    mousex = 9'h004; mouses = 1'b1;
    tick();
    mouses = 1'b0;
    chk8("collide same", d0, 8'h01);
    tick();
    chk8("collide next", d0, 8'h05);

    enable = 1'b0;
    tick();
    chk1("enable off oe", o0, 1'b0);
    chk8("enable off dout", d0, 8'hFF);
    enable = 1'b1;
    rd_port(16'hFBDF);  chk8("X kept", d0, 8'h05);

    reset = 1'b0;
    #1;
    chk1("async reset oe", o0, 1'b0);
    chk8("async reset dout", d0, 8'hFF);
    idle_bus();
    tick();
    reset = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) begin
      strobe(9'h001, 9'h000, 3'b111);
      rd_port(16'hFBDF);
      chk8($sformatf("div4 step%0d", i + 1), d2, (i == 3) ? 8'h01 : 8'h00);
    end

    // randomized traffic, checked by the model every cycle
    idle_bus();
    for (int i = 0; i < 3000; i++) begin
      int pick;
      pick   = $urandom_range(0, 5);
      mouses = ($urandom_range(0, 2) == 0);
      mousex = 9'($urandom);
      mousey = 9'($urandom);
      mouseb = 3'($urandom);
      if (pick != 5) begin
        a = 16'($urandom);
        case (pick)
          0: begin a[10:8] = 3'b011; a[5] = 1'b0; end
          1: begin a[10:8] = 3'b111; a[5] = 1'b0; end
          2: begin a[10:8] = 3'b010; a[5] = 1'b0; end
          default: ;
        endcase
        iorq = ($urandom_range(0, 3) == 0);
        rd   = ($urandom_range(0, 3) == 0);
        m1   = ($urandom_range(0, 7) != 0);
      end
      enable = ($urandom_range(0, 9) != 0);
      tick();
    end
    mouses = 1'b0;
    idle_bus();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
